// File: rtl/net_rlimit_pkg.sv
// Shared widths, the stream beat type and token clamping for the net rate limiter.
package net_rlimit_pkg;

    localparam int NET_DATA_W = 64;
    localparam int NET_KEEP_W = 8;
    localparam int RLIMIT_W   = 8;
    localparam int TOKEN_W    = 9;

    typedef struct packed {
        logic [NET_DATA_W-1:0] data;
        logic [NET_KEEP_W-1:0] keep;
        logic                  last;
    } net_beat_t;

    // The raw sum carries one extra bit so refill plus a large count never wraps.
    function automatic logic [TOKEN_W-1:0] clamp_tokens(
        input logic [TOKEN_W:0]    sum,
        input logic [RLIMIT_W-1:0] size
    );
        logic [TOKEN_W:0] size_ext;
        size_ext = {{(TOKEN_W + 1 - RLIMIT_W){1'b0}}, size};
        if (sum > size_ext) begin
            return size_ext[TOKEN_W-1:0];
        end
        return sum[TOKEN_W-1:0];
    endfunction

endpackage

// File: rtl/net_token_bucket.sv
// Token bucket: period counter drives refills, one token is spent per accepted beat.
module net_token_bucket
    import net_rlimit_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [RLIMIT_W-1:0] inc,
    input  logic [RLIMIT_W-1:0] period,
    input  logic [RLIMIT_W-1:0] size,
    input  logic                consume,
    output logic                tokens_nonzero
);

    logic [TOKEN_W-1:0]  r_tokens;
    logic [RLIMIT_W-1:0] r_period_cnt;

    logic               w_refill;
    logic               w_take;
    logic [TOKEN_W:0]   w_sum;
    logic [TOKEN_W-1:0] w_tokens_next;

    assign w_refill = (r_period_cnt == period);
    assign w_take   = consume && (r_tokens != '0);

    assign w_sum = {1'b0, r_tokens}
                 + (w_refill ? {{(TOKEN_W + 1 - RLIMIT_W){1'b0}}, inc} : '0)
                 - {{TOKEN_W{1'b0}}, w_take};

    assign w_tokens_next  = clamp_tokens(w_sum, size);
    assign tokens_nonzero = (r_tokens != '0);

    // A period lowered below the running count restarts the count instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_period_cnt <= '0;
        end else if (r_period_cnt >= period) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tokens <= '0;
        end else begin
            r_tokens <= w_tokens_next;
        end
    end

endmodule

// File: rtl/net_rate_limiter.sv
// Per-beat token-bucket rate limiter with a one-entry registered output slice.
// Optional statistics counters are built when NET_RLIMIT_STATS_EN is defined.
module net_rate_limiter
    import net_rlimit_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NET_DATA_W-1:0] in_bits_data,
    input  logic [NET_KEEP_W-1:0] in_bits_keep,
    input  logic                  in_bits_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NET_DATA_W-1:0] out_bits_data,
    output logic [NET_KEEP_W-1:0] out_bits_keep,
    output logic                  out_bits_last,
    input  logic [RLIMIT_W-1:0]   rlimit_inc,
    input  logic [RLIMIT_W-1:0]   rlimit_period,
    input  logic [RLIMIT_W-1:0]   rlimit_size
`ifdef NET_RLIMIT_STATS_EN
    ,
    output logic [31:0]           stat_beats,
    output logic [31:0]           stat_pkts,
    output logic [31:0]           stat_stall_cycles
`endif
);

    logic      w_tokens_nonzero;
    logic      w_accept;
    logic      w_out_fire;
    net_beat_t w_in_beat;

    logic      r_out_valid;
    net_beat_t r_out_beat;

    net_token_bucket u_bucket (
        .clock          (clock),
        .reset          (reset),
        .inc            (rlimit_inc),
        .period         (rlimit_period),
        .size           (rlimit_size),
        .consume        (w_accept),
        .tokens_nonzero (w_tokens_nonzero)
    );

    // Ready never looks at in_valid, so upstream may wait on it without a loop.
    assign in_ready   = w_tokens_nonzero && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    assign w_in_beat.data = in_bits_data;
    assign w_in_beat.keep = in_bits_keep;
    assign w_in_beat.last = in_bits_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_beat  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_beat  <= w_in_beat;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid     = r_out_valid;
    assign out_bits_data = r_out_beat.data;
    assign out_bits_keep = r_out_beat.keep;
    assign out_bits_last = r_out_beat.last;

`ifdef NET_RLIMIT_STATS_EN
    // Counter order: beats, packets, stall cycles.
    logic [2:0]  w_stat_inc;
    logic [31:0] r_stat_cnt [0:2];

    assign w_stat_inc[0] = w_out_fire;
    assign w_stat_inc[1] = w_out_fire && r_out_beat.last;
    assign w_stat_inc[2] = in_valid && !w_tokens_nonzero;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_stat
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_stat_cnt[gi] <= '0;
                end else if (w_stat_inc[gi]) begin
                    r_stat_cnt[gi] <= r_stat_cnt[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign stat_beats        = r_stat_cnt[0];
    assign stat_pkts         = r_stat_cnt[1];
    assign stat_stall_cycles = r_stat_cnt[2];
`else
    logic w_unused_fire;
    assign w_unused_fire = w_out_fire;
`endif

endmodule

// File: tb/tb_net_rate_limiter.sv
// Directed bench for net_rate_limiter; build with NET_RLIMIT_STATS_EN to also check the counters.
module tb_net_rate_limiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_bits_data;
    logic [7:0]  in_bits_keep;
    logic        in_bits_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_bits_data;
    logic [7:0]  out_bits_keep;
    logic        out_bits_last;
    logic [7:0]  rlimit_inc;
    logic [7:0]  rlimit_period;
    logic [7:0]  rlimit_size;
`ifdef NET_RLIMIT_STATS_EN
    logic [31:0] stat_beats;
    logic [31:0] stat_pkts;
    logic [31:0] stat_stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    int cyc;
    int sent;
    int n_beats;
    int pkt_len = 8;
    int out_cnt;
    int          rec_cyc  [0:63];
    logic [63:0] rec_data [0:63];
    logic [7:0]  rec_keep [0:63];
    logic        rec_last [0:63];

    always #5 clock = ~clock;

    net_rate_limiter dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_bits_data  (in_bits_data),
        .in_bits_keep  (in_bits_keep),
        .in_bits_last  (in_bits_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_bits_data (out_bits_data),
        .out_bits_keep (out_bits_keep),
        .out_bits_last (out_bits_last),
        .rlimit_inc    (rlimit_inc),
        .rlimit_period (rlimit_period),
        .rlimit_size   (rlimit_size)
`ifdef NET_RLIMIT_STATS_EN
        ,
        .stat_beats        (stat_beats),
        .stat_pkts         (stat_pkts),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    function automatic logic [63:0] beat_data(input int i);
        return {32'hA5A5_0000, 32'(i)};
    endfunction

    function automatic logic [7:0] beat_keep(input int i);
        return 8'hFF ^ 8'(i);
    endfunction

    // Drives the next beat, logs any handshakes seen mid-cycle, then advances one clock.
    task automatic cycle_step();
        in_valid     = (sent < n_beats);
        in_bits_data = beat_data(sent);
        in_bits_keep = beat_keep(sent);
        in_bits_last = ((sent % pkt_len) == pkt_len - 1);
        @(negedge clock);
        if (out_valid && out_ready && out_cnt < 64) begin
            rec_cyc[out_cnt]  = cyc;
            rec_data[out_cnt] = out_bits_data;
            rec_keep[out_cnt] = out_bits_keep;
            rec_last[out_cnt] = out_bits_last;
            $display("cycle %0d out beat %0d data=%h keep=%h last=%b",
                     cyc, out_cnt, out_bits_data, out_bits_keep, out_bits_last);
            out_cnt++;
        end
        if (in_valid && in_ready) sent++;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Leaves the bench at cycle 0: the first cycle with reset low.
    task automatic apply_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset   = 1'b0;
        cyc     = 0;
        sent    = 0;
        out_cnt = 0;
        n_beats = 0;
    endtask

    task automatic test_reset();
        rlimit_inc = 8'd1; rlimit_period = 8'd0; rlimit_size = 8'd8;
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_bits_data = 64'hDEAD_BEEF_0000_0001; in_bits_keep = 8'hFF; in_bits_last = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_bits_data !== 64'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_bits_data); end
        checks++; if (out_bits_keep !== 8'd0 || out_bits_last !== 1'b0) begin
            errors++; $display("FAIL reset_keep_last got=%h/%b exp=0/0", out_bits_keep, out_bits_last);
        end
`ifdef NET_RLIMIT_STATS_EN
        checks++; if (stat_beats !== 32'd0 || stat_pkts !== 32'd0 || stat_stall_cycles !== 32'd0) begin
            errors++; $display("FAIL reset_stats got=%0d/%0d/%0d exp=0/0/0", stat_beats, stat_pkts, stat_stall_cycles);
        end
`endif
    endtask

    task automatic test_full_rate();
        rlimit_inc = 8'd1; rlimit_period = 8'd0; rlimit_size = 8'd8;
        apply_reset();
        n_beats = 40; pkt_len = 8;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_rate_c0_ready got=%b exp=0", in_ready); end
        cycle_step();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL full_rate_c1 got ready=%b valid=%b exp 1/0", in_ready, out_valid);
        end
        while (cyc < 12) cycle_step();
        checks++; if (out_cnt != 10) begin errors++; $display("FAIL full_rate_count got=%0d exp=10", out_cnt); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rec_cyc[i] != 2 + i || rec_data[i] !== beat_data(i)) begin
                errors++; $display("FAIL full_rate_beat%0d got cyc=%0d data=%h exp cyc=%0d data=%h",
                                   i, rec_cyc[i], rec_data[i], 2 + i, beat_data(i));
            end
        end
    endtask

    task automatic test_paced();
        rlimit_inc = 8'd1; rlimit_period = 8'd3; rlimit_size = 8'd1;
        apply_reset();
        n_beats = 20; pkt_len = 5;
        while (cyc < 90) cycle_step();
        checks++; if (out_cnt != 20) begin errors++; $display("FAIL paced_count got=%0d exp=20", out_cnt); end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (rec_cyc[i] != 5 + 4 * i || rec_data[i] !== beat_data(i) || rec_keep[i] !== beat_keep(i)
                || rec_last[i] !== ((i % 5) == 4)) begin
                errors++; $display("FAIL paced_beat%0d got cyc=%0d data=%h keep=%h last=%b exp cyc=%0d data=%h keep=%h last=%b",
                                   i, rec_cyc[i], rec_data[i], rec_keep[i], rec_last[i],
                                   5 + 4 * i, beat_data(i), beat_keep(i), ((i % 5) == 4));
            end
        end
`ifdef NET_RLIMIT_STATS_EN
        checks++; if (stat_beats !== 32'd20 || stat_pkts !== 32'd4 || stat_stall_cycles !== 32'd61) begin
            errors++; $display("FAIL paced_stats got=%0d/%0d/%0d exp=20/4/61", stat_beats, stat_pkts, stat_stall_cycles);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int exp_cyc;
        rlimit_inc = 8'd4; rlimit_period = 8'd9; rlimit_size = 8'd8;
        apply_reset();
        while (cyc < 50) cycle_step();
        n_beats = 16; pkt_len = 16;
        while (cyc < 80) cycle_step();
        checks++; if (out_cnt != 16) begin errors++; $display("FAIL burst_count got=%0d exp=16", out_cnt); end
        for (int i = 0; i < 16; i++) begin
            exp_cyc = (i < 8) ? 51 + i : (i < 12) ? 61 + (i - 8) : 71 + (i - 12);
            checks++;
            if (rec_cyc[i] != exp_cyc || rec_data[i] !== beat_data(i)) begin
                errors++; $display("FAIL burst_beat%0d got cyc=%0d data=%h exp cyc=%0d data=%h",
                                   i, rec_cyc[i], rec_data[i], exp_cyc, beat_data(i));
            end
        end
    endtask

    task automatic test_stall();
        logic [63:0] held;
        int          sent_before;
        rlimit_inc = 8'd1; rlimit_period = 8'd0; rlimit_size = 8'd8;
        apply_reset();
        n_beats = 40; pkt_len = 8;
        while (cyc < 6) cycle_step();
        out_ready   = 1'b0;
        held        = out_bits_data;
        sent_before = sent;
        checks++; if (out_valid !== 1'b1 || held !== beat_data(4)) begin
            errors++; $display("FAIL stall_entry got valid=%b data=%h exp 1/%h", out_valid, held, beat_data(4));
        end
        repeat (5) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b1 || out_bits_data !== held || in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_hold cyc=%0d got valid=%b data=%h ready=%b exp 1/%h/0",
                                   cyc, out_valid, out_bits_data, in_ready, held);
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        checks++; if (sent != sent_before || dut.u_bucket.r_tokens !== 9'd6) begin
            errors++; $display("FAIL stall_tokens got sent=%0d tokens=%0d exp sent=%0d tokens=6",
                               sent, dut.u_bucket.r_tokens, sent_before);
        end
        out_ready = 1'b1;
        while (cyc < 21) cycle_step();
        checks++; if (out_cnt != 14) begin errors++; $display("FAIL stall_count got=%0d exp=14", out_cnt); end
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (rec_data[i] !== beat_data(i)) begin
                errors++; $display("FAIL stall_order%0d got=%h exp=%h", i, rec_data[i], beat_data(i));
            end
        end
    endtask

    task automatic test_size_lower();
        rlimit_inc = 8'd4; rlimit_period = 8'd9; rlimit_size = 8'd8;
        apply_reset();
        while (cyc < 20) cycle_step();
        checks++; if (dut.u_bucket.r_tokens !== 9'd8) begin
            errors++; $display("FAIL size_full got=%0d exp=8", dut.u_bucket.r_tokens);
        end
        rlimit_size = 8'd2;
        cycle_step();
        checks++; if (dut.u_bucket.r_tokens !== 9'd2) begin
            errors++; $display("FAIL size_clamp got=%0d exp=2", dut.u_bucket.r_tokens);
        end
        n_beats = 8; pkt_len = 8;
        while (cyc < 30) cycle_step();
        checks++; if (sent != 2) begin errors++; $display("FAIL size_before_refill got=%0d exp=2", sent); end
        while (cyc < 32) cycle_step();
        checks++; if (sent != 4) begin errors++; $display("FAIL size_after_refill got=%0d exp=4", sent); end
        rlimit_size = 8'd8;
    endtask

    task automatic test_reset_mid_packet();
        int guard = 0;
        rlimit_inc = 8'd1; rlimit_period = 8'd0; rlimit_size = 8'd8;
        apply_reset();
        n_beats = 6; pkt_len = 6;
        while (out_cnt < 3 && guard < 20) begin
            cycle_step();
            guard++;
        end
        checks++; if (out_cnt != 3 || out_valid !== 1'b1) begin
            errors++; $display("FAIL midpkt_progress got beats=%0d valid=%b exp 3/1", out_cnt, out_valid);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_bits_data !== 64'd0 || out_bits_last !== 1'b0) begin
            errors++; $display("FAIL midpkt_reset got valid=%b ready=%b data=%h last=%b exp 0/0/0/0",
                               out_valid, in_ready, out_bits_data, out_bits_last);
        end
`ifdef NET_RLIMIT_STATS_EN
        checks++; if (stat_beats !== 32'd0 || stat_pkts !== 32'd0 || stat_stall_cycles !== 32'd0) begin
            errors++; $display("FAIL midpkt_stats got=%0d/%0d/%0d exp=0/0/0", stat_beats, stat_pkts, stat_stall_cycles);
        end
`endif
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_paced();
        test_back_to_back();
        test_stall();
        test_size_lower();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
